id_stage_fwd: RTL and testbench
===============================

// Module: id_stage_fwd
// PURPOSE
//  Next-gen MIPS decode stage: decodes logic/shift/ORI/ANDI/XORI/LUI/SYNC/PREF, reads regfile,
//  resolves RAW via NUM_FWD forwarding ports, and detects load-use hazards (stall + bubble).
//  Integrates the ID/EX pipeline register: all ex_* outputs are registered. Sits between IF/ID and EX.
// PARAMETERS
//  DATA_W    32  register/operand width
//  REG_AW    5   register address width
//  NUM_FWD   2   forwarding sources; index 0 = youngest (EX), higher = older (MEM, WB...)
//  CNT_W     16  width of saturating hazard-stall counter
// PORTS
//  clk            in   1               clock, all state on rising edge
//  rst            in   1               synchronous, active-high reset
//  inst_valid_i   in   1               IF/ID holds a real instruction
//  pc_i           in   32              instruction address
//  inst_i         in   32              instruction word
//  reg1_data_i    in   DATA_W          regfile read port 1 data
//  reg2_data_i    in   DATA_W          regfile read port 2 data
//  fwd_wreg_i     in   NUM_FWD         per-source write enable
//  fwd_pend_i     in   NUM_FWD         per-source result not yet available (load in flight)
//  fwd_wd_i       in   NUM_FWD*REG_AW  per-source dest reg, source k at [k*REG_AW +: REG_AW]
//  fwd_wdata_i    in   NUM_FWD*DATA_W  per-source result, source k at [k*DATA_W +: DATA_W]
//  flush_i        in   1               kill instruction in ID; EX register loads bubble
//  ex_stall_i     in   1               EX cannot accept; ID/EX register holds
//  reg1_read_o    out  1               regfile read enable 1 (combinational)
//  reg2_read_o    out  1               regfile read enable 2 (combinational)
//  reg1_addr_o    out  REG_AW          inst_i[25:21] (combinational)
//  reg2_addr_o    out  REG_AW          inst_i[20:16] (combinational)
//  stallreq_o     out  1               load-use hazard: IF/ID must hold (combinational)
//  ex_valid_o     out  1               registered: EX holds a real instruction
//  ex_pc_o        out  32              registered pc
//  ex_aluop_o     out  8               registered `AluOpBus code
//  ex_alusel_o    out  3               registered `AluSelBus code
//  ex_reg1_o      out  DATA_W          registered operand 1
//  ex_reg2_o      out  DATA_W          registered operand 2
//  ex_wd_o        out  REG_AW          registered destination
//  ex_wreg_o      out  1               registered write enable
//  ex_illegal_o   out  1               registered: valid instruction failed decode
//  stall_cnt_o    out  CNT_W           hazard-stall cycle count, saturates at all-ones
// BEHAVIOUR
//  - Decode table and codes per defines.v; unknown opcode -> NOP, wreg=0, illegal=1.
//  - SLL/SRL/SRA only when inst_i[31:21]==0: reg1_read=0, operand1 = {0, inst_i[10:6]}.
//  - I-type: wd=inst_i[20:16]; ORI/ANDI/XORI imm={16'h0,imm16}; LUI imm={imm16,16'h0}.
//  - Operand select: read=0 -> imm; else first k (lowest index) with fwd_wreg[k] && fwd_wd[k]==addr
//    && addr!=0 -> fwd_wdata[k]; else regfile data. Address 0 never forwards; reads 0 from regfile.
//  - Hazard: inst_valid_i && !flush_i && readN && addrN!=0 && matched source k has fwd_pend[k]=1.
//    Only the winning (lowest-index) match counts; an older pending entry shadowed by a younger
//    non-pending match is not a hazard. stallreq_o = hazard && !ex_stall_i.
//  - ID/EX register update priority (rising clk):
//    1 rst: all ex_* = 0 (aluop=`EXE_NOP_OP, alusel=`EXE_RES_NOP), stall_cnt_o=0.
//    2 flush_i: bubble (valid=0, NOP, wreg=0, illegal=0, operands 0), even if ex_stall_i.
//    3 ex_stall_i: hold all ex_*.
//    4 hazard: bubble; stall_cnt_o += 1 (saturating).
//    5 else: capture decode if inst_valid_i, else bubble.
//  - Latency: decode -> ex_* one cycle. Load-use: bubble every cycle fwd_pend is set, then capture.
//  - Reset mid-stall: next cycle bubble, stallreq_o follows inputs combinationally.
//  - Combinational outputs while rst=1: read enables 0, addrs 0, stallreq_o 0.
// TESTING
//  ORI $1,$0,0x1100 -> next cycle ex_reg1=0, ex_reg2=0x00001100, ex_wd=1, wreg=1, aluop=OR.
//  fwd0(wd=3,0xAAAA) & fwd1(wd=3,0xBBBB), OR $4,$3,$3 -> both operands 0xAAAA (youngest wins).
//  fwd0 wd=0 data 0xFFFF, AND $5,$0,$2 -> ex_reg1=0; no forward on $0.
//  fwd0 pend=1 wd=2 for 2 cycles, XOR $6,$2,$1 -> stallreq 2 cycles, 2 bubbles, capture, cnt=2.
//  ex_stall_i=1 plus flush_i=1 -> bubble loaded; ex_stall_i only -> ex_* unchanged.
//  inst 0xFC000000 valid -> ex_illegal_o=1, ex_wreg_o=0, aluop=NOP.

Source files
------------

// File: rtl/id_stage_fwd_if.sv
// rtl/id_stage_fwd_if.sv - IF/ID, forwarding, regfile and ID/EX signal bundle for id_stage_fwd
interface id_stage_fwd_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    logic                        inst_valid_i;
    logic [31:0]                 pc_i;
    logic [31:0]                 inst_i;
    logic [DATA_W-1:0]           reg1_data_i;
    logic [DATA_W-1:0]           reg2_data_i;
    logic [NUM_FWD-1:0]          fwd_wreg_i;
    logic [NUM_FWD-1:0]          fwd_pend_i;
    logic [NUM_FWD*REG_AW-1:0]   fwd_wd_i;
    logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i;
    logic                        flush_i;
    logic                        ex_stall_i;
    logic                        reg1_read_o;
    logic                        reg2_read_o;
    logic [REG_AW-1:0]           reg1_addr_o;
    logic [REG_AW-1:0]           reg2_addr_o;
    logic                        stallreq_o;
    logic                        ex_valid_o;
    logic [31:0]                 ex_pc_o;
    logic [7:0]                  ex_aluop_o;
    logic [2:0]                  ex_alusel_o;
    logic [DATA_W-1:0]           ex_reg1_o;
    logic [DATA_W-1:0]           ex_reg2_o;
    logic [REG_AW-1:0]           ex_wd_o;
    logic                        ex_wreg_o;
    logic                        ex_illegal_o;
    logic [CNT_W-1:0]            stall_cnt_o;

    modport master (
        output inst_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
               fwd_wreg_i, fwd_pend_i, fwd_wd_i, fwd_wdata_i, flush_i, ex_stall_i,
        input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
               ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
               ex_wd_o, ex_wreg_o, ex_illegal_o, stall_cnt_o
    );

    modport slave (
        input  inst_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
               fwd_wreg_i, fwd_pend_i, fwd_wd_i, fwd_wdata_i, flush_i, ex_stall_i,
        output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
               ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
               ex_wd_o, ex_wreg_o, ex_illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/id_stage_fwd.sv
// rtl/id_stage_fwd.sv - MIPS decode stage with operand forwarding, load-use stall and ID/EX register
module id_stage_fwd #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst,
    id_stage_fwd_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_PREF = 6'b110011;
    localparam logic [5:0] FN_AND = 6'b100100, FN_OR = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111, FN_SYNC = 6'b001111;
    localparam logic [7:0] ALU_NOP = 8'b00000000, ALU_AND = 8'b00100100, ALU_OR = 8'b00100101;
    localparam logic [7:0] ALU_XOR = 8'b00100110, ALU_NOR = 8'b00100111, ALU_SLL = 8'b01111100;
    localparam logic [7:0] ALU_SRL = 8'b00000010, ALU_SRA = 8'b00000011;
    localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;

    logic [31:0] inst;
    logic [5:0]  op, funct;
    logic [4:0]  shamt;
    assign inst  = bus.inst_i;
    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign shamt = inst[10:6];

    logic [7:0]        d_aluop;
    logic [2:0]        d_alusel;
    logic              d_wreg, d_r1rd, d_r2rd, d_illegal;
    logic [REG_AW-1:0] d_wd;
    logic [DATA_W-1:0] d_imm;

    always_comb begin
        d_aluop   = ALU_NOP;
        d_alusel  = SEL_NOP;
        d_wreg    = 1'b0;
        d_wd      = REG_AW'(inst[15:11]);
        d_r1rd    = 1'b0;
        d_r2rd    = 1'b0;
        d_imm     = '0;
        d_illegal = 1'b1;
        // Immediate shifts are only legal with a zero rs field; otherwise fall to the R-type table.
        if (inst[31:21] == 11'd0 && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)) begin
            d_aluop   = (funct == FN_SLL) ? ALU_SLL : (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
            d_alusel  = SEL_SHIFT;
            d_wreg    = 1'b1;
            d_r2rd    = 1'b1;
            d_imm     = DATA_W'(shamt);
            d_illegal = 1'b0;
        end else begin
            case (op)
                OP_SPECIAL: begin
                    if (shamt == 5'd0) begin
                        case (funct)
                            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                                d_aluop   = (funct == FN_AND) ? ALU_AND : (funct == FN_OR) ? ALU_OR :
                                            (funct == FN_XOR) ? ALU_XOR : ALU_NOR;
                                d_alusel  = SEL_LOGIC;
                                d_wreg    = 1'b1;
                                d_r1rd    = 1'b1;
                                d_r2rd    = 1'b1;
                                d_illegal = 1'b0;
                            end
                            FN_SLLV, FN_SRLV, FN_SRAV: begin
                                d_aluop   = (funct == FN_SLLV) ? ALU_SLL : (funct == FN_SRLV) ? ALU_SRL : ALU_SRA;
                                d_alusel  = SEL_SHIFT;
                                d_wreg    = 1'b1;
                                d_r1rd    = 1'b1;
                                d_r2rd    = 1'b1;
                                d_illegal = 1'b0;
                            end
                            FN_SYNC: begin
                                d_r2rd    = 1'b1;
                                d_illegal = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                    d_aluop   = (op == OP_ANDI) ? ALU_AND : (op == OP_XORI) ? ALU_XOR : ALU_OR;
                    d_alusel  = SEL_LOGIC;
                    d_wreg    = 1'b1;
                    d_wd      = REG_AW'(inst[20:16]);
                    d_r1rd    = 1'b1;
                    d_imm     = (op == OP_LUI) ? DATA_W'({inst[15:0], 16'h0}) : DATA_W'({16'h0, inst[15:0]});
                    d_illegal = 1'b0;
                end
                OP_PREF: d_illegal = 1'b0;
                default: ;
            endcase
        end
    end

    // Returns {pending, operand}; the lowest-index matching source shadows all older ones.
    function automatic logic [DATA_W:0] pick_operand(
        input logic                      rd,
        input logic [REG_AW-1:0]         addr,
        input logic [DATA_W-1:0]         rf_data,
        input logic [DATA_W-1:0]         imm,
        input logic [NUM_FWD-1:0]        wreg,
        input logic [NUM_FWD-1:0]        pend,
        input logic [NUM_FWD*REG_AW-1:0] wd,
        input logic [NUM_FWD*DATA_W-1:0] wdata
    );
        logic           hit;
        logic [DATA_W:0] r;
        hit = 1'b0;
        r   = {1'b0, rf_data};
        if (!rd) begin
            r = {1'b0, imm};
        end else begin
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!hit && wreg[k] && wd[k*REG_AW +: REG_AW] == addr && addr != '0) begin
                    hit = 1'b1;
                    r   = {pend[k], wdata[k*DATA_W +: DATA_W]};
                end
            end
        end
        return r;
    endfunction

    logic [DATA_W:0] opnd1, opnd2;
    logic            hazard;

    assign opnd1 = pick_operand(d_r1rd, inst[25:21], bus.reg1_data_i, d_imm,
                                bus.fwd_wreg_i, bus.fwd_pend_i, bus.fwd_wd_i, bus.fwd_wdata_i);
    assign opnd2 = pick_operand(d_r2rd, inst[20:16], bus.reg2_data_i, d_imm,
                                bus.fwd_wreg_i, bus.fwd_pend_i, bus.fwd_wd_i, bus.fwd_wdata_i);
    assign hazard = bus.inst_valid_i && !bus.flush_i && (opnd1[DATA_W] || opnd2[DATA_W]);

    assign bus.reg1_read_o = !rst && d_r1rd;
    assign bus.reg2_read_o = !rst && d_r2rd;
    assign bus.reg1_addr_o = rst ? '0 : REG_AW'(inst[25:21]);
    assign bus.reg2_addr_o = rst ? '0 : REG_AW'(inst[20:16]);
    assign bus.stallreq_o  = !rst && hazard && !bus.ex_stall_i;

    logic              ex_valid, ex_wreg, ex_illegal;
    logic [31:0]       ex_pc;
    logic [7:0]        ex_aluop;
    logic [2:0]        ex_alusel;
    logic [DATA_W-1:0] ex_reg1, ex_reg2;
    logic [REG_AW-1:0] ex_wd;
    logic [CNT_W-1:0]  stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i || (!bus.ex_stall_i && (hazard || !bus.inst_valid_i))) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_aluop   <= ALU_NOP;
            ex_alusel  <= SEL_NOP;
            ex_reg1    <= '0;
            ex_reg2    <= '0;
            ex_wd      <= '0;
            ex_wreg    <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (!bus.ex_stall_i) begin
            ex_valid   <= 1'b1;
            ex_pc      <= bus.pc_i;
            ex_aluop   <= d_aluop;
            ex_alusel  <= d_alusel;
            ex_reg1    <= opnd1[DATA_W-1:0];
            ex_reg2    <= opnd2[DATA_W-1:0];
            ex_wd      <= d_wd;
            ex_wreg    <= d_wreg;
            ex_illegal <= d_illegal;
        end
        if (rst) begin
            stall_cnt <= '0;
        end else if (!bus.flush_i && !bus.ex_stall_i && hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_valid_o   = ex_valid;
    assign bus.ex_pc_o      = ex_pc;
    assign bus.ex_aluop_o   = ex_aluop;
    assign bus.ex_alusel_o  = ex_alusel;
    assign bus.ex_reg1_o    = ex_reg1;
    assign bus.ex_reg2_o    = ex_reg2;
    assign bus.ex_wd_o      = ex_wd;
    assign bus.ex_wreg_o    = ex_wreg;
    assign bus.ex_illegal_o = ex_illegal;
    assign bus.stall_cnt_o  = stall_cnt;
endmodule

// File: tb/tb_id_stage_fwd.sv
// tb/tb_id_stage_fwd.sv - scoreboard bench for id_stage_fwd against a behavioural decode/forward model
module tb_id_stage_fwd;
    localparam int DATA_W = 32, REG_AW = 5, NUM_FWD = 2, CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_fwd_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bus();
    id_stage_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [31:0] rf [0:31];
    assign bus.reg1_data_i = rf[bus.reg1_addr_o];
    assign bus.reg2_data_i = rf[bus.reg2_addr_o];

    logic        f_wreg [NUM_FWD];
    logic        f_pend [NUM_FWD];
    logic [4:0]  f_wd   [NUM_FWD];
    logic [31:0] f_data [NUM_FWD];

    typedef struct {
        logic valid; logic [31:0] pc; logic [7:0] aluop; logic [2:0] alusel;
        logic [31:0] reg1; logic [31:0] reg2; logic [4:0] wd; logic wreg; logic illegal;
    } ex_t;
    typedef struct {
        logic r1rd; logic r2rd; logic [4:0] a1; logic [4:0] a2; logic stallreq; ex_t ex; logic [15:0] cnt;
    } exp_t;
    typedef struct {
        logic [7:0] aluop; logic [2:0] alusel; logic wreg; logic [4:0] wd;
        logic use1; logic use2; logic [31:0] imm; logic ok;
    } dec_t;

    exp_t        q[$];
    ex_t         m_ex;
    logic [15:0] m_cnt;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction semantics from the MIPS encoding tables.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0] fn;
        fn = ins[5:0];
        d.aluop = 8'h00; d.alusel = 3'd0; d.wreg = 1'b0; d.wd = ins[15:11];
        d.use1 = 1'b0; d.use2 = 1'b0; d.imm = 32'h0; d.ok = 1'b0;
        if (ins[31:26] >= 6'h0c && ins[31:26] <= 6'h0f) begin
            d.aluop  = (ins[31:26] == 6'h0c) ? 8'h24 : (ins[31:26] == 6'h0e) ? 8'h26 : 8'h25;
            d.alusel = 3'd1; d.wreg = 1'b1; d.wd = ins[20:16]; d.use1 = 1'b1; d.ok = 1'b1;
            d.imm    = (ins[31:26] == 6'h0f) ? {ins[15:0], 16'h0} : {16'h0, ins[15:0]};
        end else if (ins[31:26] == 6'h33) begin
            d.ok = 1'b1;
        end else if (ins[31:21] == 11'd0 && (fn == 6'd0 || fn == 6'd2 || fn == 6'd3)) begin
            d.aluop  = (fn == 6'd0) ? 8'h7c : {2'b00, fn};
            d.alusel = 3'd2; d.wreg = 1'b1; d.use2 = 1'b1; d.imm = {27'd0, ins[10:6]}; d.ok = 1'b1;
        end else if (ins[31:26] == 6'h00 && ins[10:6] == 5'd0) begin
            if (fn >= 6'h24 && fn <= 6'h27) begin
                d.aluop = {2'b00, fn}; d.alusel = 3'd1; d.wreg = 1'b1;
                d.use1 = 1'b1; d.use2 = 1'b1; d.ok = 1'b1;
            end else if (fn == 6'd4 || fn == 6'd6 || fn == 6'd7) begin
                d.aluop = (fn == 6'd4) ? 8'h7c : {2'b00, fn - 6'd4}; d.alusel = 3'd2; d.wreg = 1'b1;
                d.use1 = 1'b1; d.use2 = 1'b1; d.ok = 1'b1;
            end else if (fn == 6'h0f) begin
                d.use2 = 1'b1; d.ok = 1'b1;
            end
        end
        return d;
    endfunction

    // {pending, value}: youngest producer of the register wins, $0 is constant zero.
    function automatic logic [32:0] ref_opnd(input logic use_reg, input logic [4:0] a, input logic [31:0] imm);
        if (!use_reg) return {1'b0, imm};
        if (a == 5'd0) return 33'd0;
        for (int k = 0; k < NUM_FWD; k++)
            if (f_wreg[k] && f_wd[k] == a) return {f_pend[k], f_data[k]};
        return {1'b0, rf[a]};
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic st);
        exp_t e; dec_t d; ex_t bub; logic [32:0] o1, o2; logic haz;
        @(negedge clk);
        rst = r; bus.inst_valid_i = v; bus.pc_i = pc; bus.inst_i = ins;
        bus.flush_i = fl; bus.ex_stall_i = st;
        for (int k = 0; k < NUM_FWD; k++) begin
            bus.fwd_wreg_i[k] = f_wreg[k];
            bus.fwd_pend_i[k] = f_pend[k];
            bus.fwd_wd_i[k*REG_AW +: REG_AW] = f_wd[k];
            bus.fwd_wdata_i[k*DATA_W +: DATA_W] = f_data[k];
        end
        #1;
        d   = ref_decode(ins);
        o1  = ref_opnd(d.use1, ins[25:21], d.imm);
        o2  = ref_opnd(d.use2, ins[20:16], d.imm);
        haz = v && !fl && (o1[32] || o2[32]);
        e.r1rd = !r && d.use1; e.r2rd = !r && d.use2;
        e.a1 = r ? 5'd0 : ins[25:21]; e.a2 = r ? 5'd0 : ins[20:16];
        e.stallreq = !r && haz && !st;
        bub = '{valid: 1'b0, pc: 32'h0, aluop: 8'h0, alusel: 3'h0, reg1: 32'h0, reg2: 32'h0,
                wd: 5'h0, wreg: 1'b0, illegal: 1'b0};
        if (r) begin
            m_ex = bub; m_cnt = 16'd0;
        end else if (fl) begin
            m_ex = bub;
        end else if (st) begin
            m_ex = m_ex;
        end else if (haz) begin
            m_ex = bub;
            if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
        end else if (v) begin
            m_ex = '{valid: 1'b1, pc: pc, aluop: d.aluop, alusel: d.alusel, reg1: o1[31:0], reg2: o2[31:0],
                     wd: d.wd, wreg: d.wreg, illegal: !d.ok};
        end else begin
            m_ex = bub;
        end
        e.ex = m_ex; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("reg1_read", 32'(bus.reg1_read_o), 32'(e.r1rd));
                chk("reg2_read", 32'(bus.reg2_read_o), 32'(e.r2rd));
                chk("reg1_addr", 32'(bus.reg1_addr_o), 32'(e.a1));
                chk("reg2_addr", 32'(bus.reg2_addr_o), 32'(e.a2));
                chk("stallreq",  32'(bus.stallreq_o),  32'(e.stallreq));
                @(posedge clk); #1;
                chk("ex_valid",   32'(bus.ex_valid_o),   32'(e.ex.valid));
                chk("ex_aluop",   32'(bus.ex_aluop_o),   32'(e.ex.aluop));
                chk("ex_alusel",  32'(bus.ex_alusel_o),  32'(e.ex.alusel));
                chk("ex_reg1",    bus.ex_reg1_o,         e.ex.reg1);
                chk("ex_reg2",    bus.ex_reg2_o,         e.ex.reg2);
                chk("ex_wreg",    32'(bus.ex_wreg_o),    32'(e.ex.wreg));
                chk("ex_illegal", 32'(bus.ex_illegal_o), 32'(e.ex.illegal));
                chk("stall_cnt",  32'(bus.stall_cnt_o),  32'(e.cnt));
                if (e.ex.valid) chk("ex_pc", bus.ex_pc_o, e.ex.pc);
                if (e.ex.wreg)  chk("ex_wd", 32'(bus.ex_wd_o), 32'(e.ex.wd));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd, sa; logic [5:0] x; logic [15:0] imm;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        sa = 5'($urandom_range(0, 31)); imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       begin x = 6'(6'h0c + $urandom_range(0, 3)); return {x, rs, rt, imm}; end
            1, 2, 3: begin x = 6'(6'h24 + $urandom_range(0, 3)); return {6'h0, rs, rt, rd, 5'h0, x}; end
            4:       begin x = ($urandom_range(0, 2) == 0) ? 6'd4 : 6'(6'd5 + $urandom_range(1, 2));
                           return {6'h0, rs, rt, rd, 5'h0, x}; end
            5:       begin x = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'(6'd1 + $urandom_range(1, 2));
                           return {11'h0, rt, rd, sa, x}; end
            6:       return {6'h0, rs, rt, rd, 5'h0, 6'h0f};
            7:       return {6'h33, rs, rt, imm};
            8:       return $urandom;
            default: return {6'h3f, 26'($urandom)};
        endcase
    endfunction

    task automatic clear_fwd();
        for (int k = 0; k < NUM_FWD; k++) begin
            f_wreg[k] = 1'b0; f_pend[k] = 1'b0; f_wd[k] = 5'd0; f_data[k] = 32'h0;
        end
    endtask

    initial begin : stimulus
        bus.inst_valid_i = 1'b0; bus.pc_i = 32'h0; bus.inst_i = 32'h0;
        bus.flush_i = 1'b0; bus.ex_stall_i = 1'b0;
        bus.fwd_wreg_i = '0; bus.fwd_pend_i = '0; bus.fwd_wd_i = '0; bus.fwd_wdata_i = '0;
        m_cnt = 16'd0;
        rf[0] = 32'h0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        clear_fwd();

        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        cycle(1, 1, 32'h4, 32'h34011100, 0, 0);
        cycle(0, 1, 32'h100, 32'h34011100, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("ori_reg2", bus.ex_reg2_o, 32'h00001100);
        chk("ori_aluop", 32'(bus.ex_aluop_o), 32'h25);

        f_wreg[0] = 1'b1; f_wd[0] = 5'd3; f_data[0] = 32'hAAAA;
        f_wreg[1] = 1'b1; f_wd[1] = 5'd3; f_data[1] = 32'hBBBB;
        cycle(0, 1, 32'h104, 32'h00632025, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("youngest_reg1", bus.ex_reg1_o, 32'hAAAA);
        chk("youngest_reg2", bus.ex_reg2_o, 32'hAAAA);

        clear_fwd();
        f_wreg[0] = 1'b1; f_wd[0] = 5'd0; f_data[0] = 32'hFFFF;
        cycle(0, 1, 32'h108, 32'h00022824, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("zero_no_fwd", bus.ex_reg1_o, 32'h0);

        clear_fwd();
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        f_wreg[0] = 1'b1; f_wd[0] = 5'd2; f_pend[0] = 1'b1; f_data[0] = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 32'h10c, 32'h00413026, 0, 0);
            chk("load_use_stallreq", 32'(bus.stallreq_o), 32'd1);
        end
        f_pend[0] = 1'b0;
        cycle(0, 1, 32'h10c, 32'h00413026, 0, 0);
        chk("load_use_release", 32'(bus.stallreq_o), 32'd0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("load_use_cnt", 32'(bus.stall_cnt_o), 32'd2);
        chk("load_use_reg1", bus.ex_reg1_o, 32'h1234_5678);

        clear_fwd();
        cycle(0, 1, 32'h200, 32'h34011100, 0, 0);
        cycle(0, 1, 32'h204, 32'h34021234, 1, 1);
        cycle(0, 1, 32'h208, 32'h34031111, 0, 0);
        chk("flush_over_stall", 32'(bus.ex_valid_o), 32'd0);
        cycle(0, 1, 32'h20c, 32'h38045555, 0, 1);
        cycle(0, 1, 32'hfc0, 32'hFC000000, 0, 0);
        chk("stall_hold_pc", bus.ex_pc_o, 32'h208);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("illegal_flag", 32'(bus.ex_illegal_o), 32'd1);
        chk("illegal_wreg", 32'(bus.ex_wreg_o), 32'd0);

        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                f_wreg[k] = ($urandom_range(0, 3) != 0);
                f_wd[k]   = 5'($urandom_range(0, 7));
                f_pend[k] = ($urandom_range(0, 6) == 0);
                f_data[k] = $urandom;
            end
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), $urandom, rand_inst(),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
        end

        for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
